dcpu_prefetch: RTL and testbench

//  Instruction prefetch unit between the dcpu fetch/decode stage and the Wishbone bus.

---
 rtl/dcpu_pkg.sv | 23 ++
 rtl/dcpu_ins_fifo.sv | 79 +++++++
 rtl/dcpu_prefetch.sv | 124 ++++++++++++
 tb/tb_dcpu_prefetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// dcpu shared definitions: address/instruction widths, prefetch state encoding,
// the queued instruction entry type and the big-endian halfword select helper.
package dcpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned INS_W  = 16;

    typedef enum logic [0:0] {
        PF_IDLE,
        PF_REQ
    } pf_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  ins;
    } ins_entry_t;

    // Big-endian: the lower halfword address lives in the upper bus lane.
    function automatic logic [INS_W-1:0] hw_select(input logic [31:0] dat, input logic pc_bit1);
        return pc_bit1 ? dat[15:0] : dat[31:16];
    endfunction

endpackage

// File: rtl/dcpu_ins_fifo.sv
// Synchronous FIFO of {pc, ins} entries for the dcpu prefetch unit.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_clear                 drop all entries (wins over push/pop)
//   i_push0/i_push0_data    first entry pushed this cycle
//   i_push1/i_push1_data    second entry, stored behind push0 when both are set
//   i_pop                   advance head (ignored when empty)
//   o_head                  entry at the head
//   o_count, o_free         occupancy and remaining room
module dcpu_ins_fifo
    import dcpu_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_push0,
    input  ins_entry_t            i_push0_data,
    input  logic                  i_push1,
    input  ins_entry_t            i_push1_data,
    input  logic                  i_pop,
    output ins_entry_t            o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [DEPTH_LOG2:0]   o_free
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    ins_entry_t mem_q [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    ptr_t       wr1_ptr;
    cnt_t       n_push;
    logic       pop_en;

    always_comb begin
        pop_en   = i_pop && (count_q != '0);
        n_push   = cnt_t'(i_push0) + cnt_t'(i_push1);
        // push1 lands one slot after push0 only when push0 also writes
        wr1_ptr  = wr_ptr_q + ptr_t'(i_push0);
        wr_ptr_d = wr_ptr_q + ptr_t'(n_push);
        rd_ptr_d = rd_ptr_q + ptr_t'(pop_en);
        count_d  = count_q + n_push - cnt_t'(pop_en);
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_clear) begin
            if (i_push0) mem_q[wr_ptr_q] <= i_push0_data;
            if (i_push1) mem_q[wr1_ptr]  <= i_push1_data;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_free  = cnt_t'(DEPTH) - count_q;

endmodule

// File: rtl/dcpu_prefetch.sv
// dcpu instruction prefetch: fetches 32-bit words over Wishbone, splits them into
// two 16-bit instructions (big-endian) and hands them out one per cycle.
// Ports:
//   i_clk, i_reset                       clock, synchronous active-high reset
//   o_wb_cyc/stb/addr/sel/we             Wishbone read master
//   i_wb_ack, i_wb_dat                   read response
//   o_ins_valid, o_ins, o_ins_pc         head instruction and its byte address
//   i_ins_ready                          consumer accepts head
//   i_flush, i_flush_pc                  discard queue and restart at i_flush_pc
module dcpu_prefetch
    import dcpu_pkg::*;
#(
    parameter int unsigned      DEPTH_LOG2 = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic [31:0]       o_wb_addr,
    output logic [3:0]        o_wb_sel,
    output logic              o_wb_we,
    input  logic              i_wb_ack,
    input  logic [31:0]       i_wb_dat,
    output logic              o_ins_valid,
    output logic [INS_W-1:0]  o_ins,
    output logic [ADDR_W-1:0] o_ins_pc,
    input  logic              i_ins_ready,
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;

    pf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              discard_q, discard_d;

    logic              ack;
    logic              push0, push1, pop;
    ins_entry_t        push0_data, push1_data, head;
    logic [CW-1:0]     count, free;
    logic [ADDR_W-1:0] fetch_aligned;
    logic              unused_flush_pc0;

    assign unused_flush_pc0 = i_flush_pc[0];

    // Acks outside an active cycle are ignored.
    assign ack           = (state_q == PF_REQ) && i_wb_ack;
    assign fetch_aligned = {fetch_pc_q[ADDR_W-1:2], 2'b00};
    assign pop           = o_ins_valid && i_ins_ready;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        push0      = 1'b0;
        push1      = 1'b0;
        push0_data = '{pc: fetch_pc_q, ins: hw_select(i_wb_dat, fetch_pc_q[1])};
        push1_data = '{pc: fetch_pc_q + 16'd2, ins: i_wb_dat[15:0]};

        unique case (state_q)
            PF_IDLE: begin
                // Two free slots cover the worst case of a full word push.
                if (!i_flush && (free >= CW'(2))) state_d = PF_REQ;
            end
            PF_REQ: begin
                if (ack) begin
                    state_d   = PF_IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !i_flush) begin
                        push0      = 1'b1;
                        push1      = !fetch_pc_q[1];
                        fetch_pc_d = fetch_aligned + 16'd4;
                    end
                end else if (i_flush) begin
                    // Bus cycle cannot be abandoned; drop its data when it lands.
                    discard_d = 1'b1;
                end
            end
            default: state_d = PF_IDLE;
        endcase

        if (i_flush) fetch_pc_d = {i_flush_pc[ADDR_W-1:1], 1'b0};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= PF_IDLE;
            fetch_pc_q <= {RESET_PC[ADDR_W-1:1], 1'b0};
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

    dcpu_ins_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_flush),
        .i_push0      (push0),
        .i_push0_data (push0_data),
        .i_push1      (push1),
        .i_push1_data (push1_data),
        .i_pop        (pop),
        .o_head       (head),
        .o_count      (count),
        .o_free       (free)
    );

    assign o_wb_cyc    = (state_q == PF_REQ);
    assign o_wb_stb    = o_wb_cyc;
    assign o_wb_addr   = {16'h0, fetch_aligned};
    assign o_wb_sel    = 4'b1111;
    assign o_wb_we     = 1'b0;
    assign o_ins_valid = (count != '0);
    assign o_ins       = head.ins;
    assign o_ins_pc    = head.pc;

endmodule

// File: tb/tb_dcpu_prefetch.sv
module tb_dcpu_prefetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic        i_wb_ack = 1'b0;
    logic [31:0] i_wb_dat = 32'h0;
    logic        o_ins_valid;
    logic [15:0] o_ins, o_ins_pc;
    logic        i_ins_ready;
    logic        i_flush;
    logic [15:0] i_flush_pc;

    int tests = 0;
    int fails = 0;

    // Slave memory and wait-state control
    logic [31:0] mem [0:16383];
    int          wait_n = 0;
    int          wcnt   = 0;

    // Golden model state: expected queue of {pc, ins}, expected fetch pc, discard flag
    logic [31:0] sb_q [$];
    logic [15:0] mpc  = 16'h0;
    logic        disc = 1'b0;

    dcpu_prefetch #(
        .DEPTH_LOG2 (2),
        .RESET_PC   (16'h0)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_addr   (o_wb_addr),
        .o_wb_sel    (o_wb_sel),
        .o_wb_we     (o_wb_we),
        .i_wb_ack    (i_wb_ack),
        .i_wb_dat    (i_wb_dat),
        .o_ins_valid (o_ins_valid),
        .o_ins       (o_ins),
        .o_ins_pc    (o_ins_pc),
        .i_ins_ready (i_ins_ready),
        .i_flush     (i_flush),
        .i_flush_pc  (i_flush_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        int k = 0;
        while (!o_wb_cyc && k < n) begin
            step();
            k++;
        end
        chk("wait_cyc", {31'h0, o_wb_cyc}, 32'h1);
    endtask

    task automatic wait_valid(input int n);
        int k = 0;
        while (!o_ins_valid && k < n) begin
            step();
            k++;
        end
        chk("wait_valid", {31'h0, o_ins_valid}, 32'h1);
    endtask

    task automatic do_flush(input logic [15:0] pc);
        i_flush    = 1'b1;
        i_flush_pc = pc;
        step();
        i_flush    = 1'b0;
    endtask

    task automatic quiesce();
        i_ins_ready = 1'b0;
        repeat (30) step();
    endtask

    task automatic check_no_cyc(input int n);
        for (int k = 0; k < n; k++) begin
            chk("no_cyc", {31'h0, o_wb_cyc}, 32'h0);
            step();
        end
    endtask

    // Wishbone slave: acks wait_n cycles after the first cycle cyc is seen
    always @(posedge i_clk) begin
        if (!o_wb_cyc || i_wb_ack) begin
            i_wb_ack <= 1'b0;
            wcnt     <= 0;
        end else if (wcnt >= wait_n) begin
            i_wb_ack <= 1'b1;
            i_wb_dat <= mem[o_wb_addr[15:2]];
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Scoreboard: sampled mid-cycle, sees the inputs and outputs feeding the next edge
    always @(negedge i_clk) begin
        logic [31:0] e;
        if (i_reset) begin
            sb_q.delete();
            mpc  = 16'h0;
            disc = 1'b0;
        end else begin
            chk("valid", {31'h0, o_ins_valid}, {31'h0, sb_q.size() != 0});
            if (o_ins_valid && i_ins_ready && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ins", {16'h0, o_ins}, {16'h0, e[15:0]});
                chk("ins_pc", {16'h0, o_ins_pc}, {16'h0, e[31:16]});
            end
            if (o_wb_cyc && !disc) chk("addr", o_wb_addr, {16'h0, mpc[15:2], 2'b00});
            if (i_flush) begin
                sb_q.delete();
                mpc = {i_flush_pc[15:1], 1'b0};
                if (o_wb_cyc && i_wb_ack) disc = 1'b0;
                else if (o_wb_cyc) disc = 1'b1;
            end else if (o_wb_cyc && i_wb_ack) begin
                if (!disc) begin
                    if (!mpc[1]) begin
                        sb_q.push_back({mpc, i_wb_dat[31:16]});
                        sb_q.push_back({mpc + 16'd2, i_wb_dat[15:0]});
                    end else begin
                        sb_q.push_back({mpc, i_wb_dat[15:0]});
                    end
                    mpc = {mpc[15:2], 2'b00} + 16'd4;
                end
                disc = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = {16'(i) ^ 16'h5A5A, ~16'(i)};
        mem[14'h0000] = 32'h11112222;
        mem[14'h0004] = 32'hAAAABBBB;
        mem[14'h0040] = 32'hC0DE0100;
        mem[14'h0080] = 32'hD00D0200;
        mem[14'h3FFF] = 32'h12345678;

        i_reset     = 1'b1;
        i_ins_ready = 1'b1;
        i_flush     = 1'b0;
        i_flush_pc  = 16'h0;
        repeat (3) step();
        chk("rst_cyc", {31'h0, o_wb_cyc}, 32'h0);
        chk("rst_valid", {31'h0, o_ins_valid}, 32'h0);
        chk("rst_sel", {28'h0, o_wb_sel}, 32'hF);
        chk("rst_we", {31'h0, o_wb_we}, 32'h0);
        i_reset = 1'b0;

        // 1: first fetch after reset
        wait_cyc(10);
        chk("t1_addr0", o_wb_addr, 32'h0);
        wait_valid(20);
        chk("t1_ins0", {16'h0, o_ins}, 32'h1111);
        chk("t1_pc0", {16'h0, o_ins_pc}, 32'h0);
        step();
        chk("t1_ins1", {16'h0, o_ins}, 32'h2222);
        chk("t1_pc1", {16'h0, o_ins_pc}, 32'h2);
        chk("t1_cyc1", {31'h0, o_wb_cyc}, 32'h1);
        chk("t1_addr1", o_wb_addr, 32'h4);

        // 2: flush to an odd halfword
        quiesce();
        do_flush(16'h0012);
        wait_valid(20);
        chk("t2_ins", {16'h0, o_ins}, 32'hBBBB);
        chk("t2_pc", {16'h0, o_ins_pc}, 32'h12);
        wait_cyc(10);
        chk("t2_addr", o_wb_addr, 32'h14);

        // 3: full queue throttles fetching
        quiesce();
        do_flush(16'h0020);
        repeat (15) step();
        check_no_cyc(8);
        i_ins_ready = 1'b1;
        step();
        i_ins_ready = 1'b0;
        check_no_cyc(6);
        i_ins_ready = 1'b1;
        step();
        i_ins_ready = 1'b0;
        wait_cyc(10);
        chk("t3_addr", o_wb_addr, 32'h28);

        // 4: flush during a wait-stated request
        wait_n      = 3;
        i_ins_ready = 1'b1;
        repeat (12) step();
        while (o_wb_cyc) step();
        wait_cyc(20);
        step();
        do_flush(16'h0100);
        for (int k = 0; k < 10 && !i_wb_ack; k++) begin
            chk("t4_cyc_hold", {31'h0, o_wb_cyc}, 32'h1);
            step();
        end
        chk("t4_ack", {31'h0, i_wb_ack}, 32'h1);
        step();
        chk("t4_cyc_end", {31'h0, o_wb_cyc}, 32'h0);
        chk("t4_empty", {31'h0, o_ins_valid}, 32'h0);
        wait_cyc(10);
        chk("t4_addr", o_wb_addr, 32'h100);
        wait_valid(20);
        chk("t4_pc", {16'h0, o_ins_pc}, 32'h100);
        chk("t4_ins", {16'h0, o_ins}, 32'hC0DE);

        // 5: flush in the ack cycle
        wait_n = 0;
        for (int k = 0; k < 40 && !i_wb_ack; k++) step();
        chk("t5_ack", {31'h0, i_wb_ack}, 32'h1);
        do_flush(16'h0200);
        chk("t5_empty", {31'h0, o_ins_valid}, 32'h0);
        chk("t5_cyc", {31'h0, o_wb_cyc}, 32'h0);
        wait_cyc(10);
        chk("t5_addr", o_wb_addr, 32'h200);
        wait_valid(20);
        chk("t5_pc", {16'h0, o_ins_pc}, 32'h200);
        chk("t5_ins", {16'h0, o_ins}, 32'hD00D);

        // 6: address wrap, then random consumer/flush traffic against the model
        quiesce();
        do_flush(16'hFFFC);
        wait_valid(20);
        chk("t6_ins0", {16'h0, o_ins}, 32'h1234);
        chk("t6_pc0", {16'h0, o_ins_pc}, 32'hFFFC);
        i_ins_ready = 1'b1;
        step();
        chk("t6_valid1", {31'h0, o_ins_valid}, 32'h1);
        chk("t6_ins1", {16'h0, o_ins}, 32'h5678);
        chk("t6_pc1", {16'h0, o_ins_pc}, 32'hFFFE);
        wait_cyc(10);
        chk("t6_addr", o_wb_addr, 32'h0);
        for (int k = 0; k < 400; k++) begin
            i_ins_ready = 1'($urandom_range(0, 1));
            wait_n      = $urandom_range(0, 2);
            i_flush     = ($urandom_range(0, 31) == 0);
            i_flush_pc  = 16'($urandom());
            step();
        end
        i_flush = 1'b0;

        // Reset in the middle of a bus cycle
        wait_cyc(20);
        i_reset = 1'b1;
        step();
        chk("rst2_cyc", {31'h0, o_wb_cyc}, 32'h0);
        chk("rst2_valid", {31'h0, o_ins_valid}, 32'h0);
        i_reset = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
